multicycle_control: RTL and testbench

//  Multi-cycle MIPS control FSM; successor to the single-cycle opcode decoder.

---
 rtl/multicycle_control_if.sv | 37 +++
 rtl/multicycle_control.sv | 154 +++++++++++++++
 tb/tb_multicycle_control.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Bundles the control FSM's datapath strobes and shared-memory handshake.
// The master modport is the controller; the slave modport is the datapath/memory side.
interface multicycle_control_if #(
    parameter int unsigned OP_W = 6
);
    logic [OP_W-1:0] Op_i;
    logic            Zero_i;
    logic            MemAck_i;
    logic            MemReq_o;
    logic            MemWrite_o;
    logic            IorD_o;
    logic            IRWrite_o;
    logic            PCWrite_o;
    logic [1:0]      PCSource_o;
    logic            ALUSrcA_o;
    logic [1:0]      ALUSrcB_o;
    logic [1:0]      ALUOp_o;
    logic            RegDst_o;
    logic            RegWrite_o;
    logic            MemToReg_o;
    logic            InstrDone_o;
    logic            Err_o;

    modport master (
        input  Op_i, Zero_i, MemAck_i,
        output MemReq_o, MemWrite_o, IorD_o, IRWrite_o, PCWrite_o, PCSource_o,
               ALUSrcA_o, ALUSrcB_o, ALUOp_o, RegDst_o, RegWrite_o, MemToReg_o,
               InstrDone_o, Err_o
    );

    modport slave (
        output Op_i, Zero_i, MemAck_i,
        input  MemReq_o, MemWrite_o, IorD_o, IRWrite_o, PCWrite_o, PCSource_o,
               ALUSrcA_o, ALUSrcB_o, ALUOp_o, RegDst_o, RegWrite_o, MemToReg_o,
               InstrDone_o, Err_o
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over one shared memory port, trapping on an illegal opcode or a memory timeout.
module multicycle_control #(
    parameter int unsigned OP_W        = 6,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned HAS_JUMP    = 1
) (
    input logic                clk_i,
    input logic                rst_i,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        StRst, StFetch, StDecode, StExecR, StWbR, StExecI, StWbI, StMemAddr,
        StMemRd, StMemWr, StWbMem, StBranch, StJump, StTrap
    } state_e;

    localparam logic [5:0] OpR    = 6'b000000;
    localparam logic [5:0] OpAddi = 6'b001000;
    localparam logic [5:0] OpLw   = 6'b100011;
    localparam logic [5:0] OpSw   = 6'b101011;
    localparam logic [5:0] OpBeq  = 6'b000100;
    localparam logic [5:0] OpJ    = 6'b000010;

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       store_q, store_d;
    logic       timeout;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StRst;
            wait_q  <= '0;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            store_q <= store_d;
        end
    end

    // Only meaningful in request states; ack in the limit cycle beats the trap.
    assign timeout = (wait_q == 8'(MEM_TIMEOUT)) && !bus.MemAck_i;

    always_comb begin
        state_d         = state_q;
        store_d         = store_q;
        wait_d          = '0;
        bus.MemReq_o    = 1'b0;
        bus.MemWrite_o  = 1'b0;
        bus.IorD_o      = 1'b0;
        bus.IRWrite_o   = 1'b0;
        bus.PCWrite_o   = 1'b0;
        bus.PCSource_o  = 2'b00;
        bus.ALUSrcA_o   = 1'b0;
        bus.ALUSrcB_o   = 2'b00;
        bus.ALUOp_o     = 2'b00;
        bus.RegDst_o    = 1'b0;
        bus.RegWrite_o  = 1'b0;
        bus.MemToReg_o  = 1'b0;
        bus.InstrDone_o = 1'b0;
        bus.Err_o       = 1'b0;

        unique case (state_q)
            StRst: state_d = StFetch;
            StFetch: begin
                bus.MemReq_o = 1'b1;
                if (bus.MemAck_i) begin
                    bus.IRWrite_o = 1'b1;
                    bus.PCWrite_o = 1'b1;
                    bus.ALUSrcB_o = 2'b01;
                    state_d       = StDecode;
                end else if (timeout) begin
                    state_d = StTrap;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StDecode: begin
                bus.ALUSrcB_o = 2'b11;
                state_d       = StTrap;
                if (bus.Op_i == OP_W'(OpR))    state_d = StExecR;
                if (bus.Op_i == OP_W'(OpAddi)) state_d = StExecI;
                if (bus.Op_i == OP_W'(OpLw) || bus.Op_i == OP_W'(OpSw)) state_d = StMemAddr;
                if (bus.Op_i == OP_W'(OpBeq))  state_d = StBranch;
                if (bus.Op_i == OP_W'(OpJ) && HAS_JUMP != 0) state_d = StJump;
                store_d = (bus.Op_i == OP_W'(OpSw));
            end
            StExecR: begin
                bus.ALUSrcA_o = 1'b1;
                bus.ALUOp_o   = 2'b10;
                state_d       = StWbR;
            end
            StWbR: begin
                bus.RegDst_o    = 1'b1;
                bus.RegWrite_o  = 1'b1;
                bus.InstrDone_o = 1'b1;
                state_d         = StFetch;
            end
            StExecI: begin
                bus.ALUSrcA_o = 1'b1;
                bus.ALUSrcB_o = 2'b10;
                state_d       = StWbI;
            end
            StWbI: begin
                bus.RegWrite_o  = 1'b1;
                bus.InstrDone_o = 1'b1;
                state_d         = StFetch;
            end
            StMemAddr: begin
                bus.ALUSrcA_o = 1'b1;
                bus.ALUSrcB_o = 2'b10;
                state_d       = store_q ? StMemWr : StMemRd;
            end
            StMemRd: begin
                bus.MemReq_o = 1'b1;
                bus.IorD_o   = 1'b1;
                if (bus.MemAck_i)  state_d = StWbMem;
                else if (timeout)  state_d = StTrap;
                else               wait_d  = wait_q + 8'd1;
            end
            StMemWr: begin
                bus.MemReq_o    = 1'b1;
                bus.MemWrite_o  = 1'b1;
                bus.IorD_o      = 1'b1;
                bus.InstrDone_o = bus.MemAck_i;
                if (bus.MemAck_i)  state_d = StFetch;
                else if (timeout)  state_d = StTrap;
                else               wait_d  = wait_q + 8'd1;
            end
            StWbMem: begin
                bus.RegWrite_o  = 1'b1;
                bus.MemToReg_o  = 1'b1;
                bus.InstrDone_o = 1'b1;
                state_d         = StFetch;
            end
            StBranch: begin
                bus.ALUSrcA_o   = 1'b1;
                bus.ALUOp_o     = 2'b01;
                bus.PCSource_o  = 2'b01;
                bus.PCWrite_o   = bus.Zero_i;
                bus.InstrDone_o = 1'b1;
                state_d         = StFetch;
            end
            StJump: begin
                bus.PCSource_o  = 2'b10;
                bus.PCWrite_o   = 1'b1;
                bus.InstrDone_o = 1'b1;
                state_d         = StFetch;
            end
            StTrap: bus.Err_o = 1'b1;
            default: state_d = StTrap;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction cycle-by-cycle expectations built
// from instruction class, random memory wait counts and random don't-care inputs.
module tb_multicycle_control;
    localparam int TO = 15;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam int PH_IDLE = 0, PH_FETCH = 1, PH_DEC = 2, PH_EXR = 3, PH_WBR = 4,
                   PH_EXI = 5, PH_WBI = 6, PH_ADDR = 7, PH_RD = 8, PH_WR = 9,
                   PH_WBM = 10, PH_BR = 11, PH_JMP = 12, PH_TRAP = 13;

    typedef struct packed {
        logic       req, wr, iord, irw, pcw;
        logic [1:0] pcs;
        logic       srca;
        logic [1:0] srcb, aluop;
        logic       regdst, regw, m2r, done, err;
    } outs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multicycle_control_if #(.OP_W(6)) bus ();
    multicycle_control_if #(.OP_W(6)) bus_nj ();

    assign bus_nj.Op_i     = bus.Op_i;
    assign bus_nj.Zero_i   = bus.Zero_i;
    assign bus_nj.MemAck_i = bus.MemAck_i;

    multicycle_control #(.OP_W(6), .MEM_TIMEOUT(TO), .HAS_JUMP(1)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    multicycle_control #(.OP_W(6), .MEM_TIMEOUT(TO), .HAS_JUMP(0)) u_dut_nj (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_nj)
    );

    function automatic outs_t observe();
        return {bus.MemReq_o, bus.MemWrite_o, bus.IorD_o, bus.IRWrite_o, bus.PCWrite_o,
                bus.PCSource_o, bus.ALUSrcA_o, bus.ALUSrcB_o, bus.ALUOp_o, bus.RegDst_o,
                bus.RegWrite_o, bus.MemToReg_o, bus.InstrDone_o, bus.Err_o};
    endfunction

    function automatic outs_t expect_ph(input int ph, input logic ack, input logic zero);
        outs_t e;
        e = '0;
        case (ph)
            PH_FETCH: begin
                e.req = 1'b1;
                if (ack) begin e.irw = 1'b1; e.pcw = 1'b1; e.srcb = 2'b01; end
            end
            PH_DEC:  e.srcb = 2'b11;
            PH_EXR:  begin e.srca = 1'b1; e.aluop = 2'b10; end
            PH_WBR:  begin e.regdst = 1'b1; e.regw = 1'b1; e.done = 1'b1; end
            PH_EXI, PH_ADDR: begin e.srca = 1'b1; e.srcb = 2'b10; end
            PH_WBI:  begin e.regw = 1'b1; e.done = 1'b1; end
            PH_RD:   begin e.req = 1'b1; e.iord = 1'b1; end
            PH_WR:   begin e.req = 1'b1; e.wr = 1'b1; e.iord = 1'b1; e.done = ack; end
            PH_WBM:  begin e.regw = 1'b1; e.m2r = 1'b1; e.done = 1'b1; end
            PH_BR: begin
                e.srca = 1'b1; e.aluop = 2'b01; e.pcs = 2'b01; e.pcw = zero; e.done = 1'b1;
            end
            PH_JMP:  begin e.pcs = 2'b10; e.pcw = 1'b1; e.done = 1'b1; end
            PH_TRAP: e.err = 1'b1;
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic check(input outs_t e, input string tag);
        outs_t o;
        o = observe();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, then sample the outputs.
    task automatic cycle(input outs_t e, input logic ack, input logic [5:0] op,
                         input logic zero, input string tag);
        @(negedge clk);
        bus.MemAck_i = ack;
        bus.Op_i     = op;
        bus.Zero_i   = zero;
        #1;
        check(e, tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check('0, "reset_outputs");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic trap_tail(input string tag);
        for (int i = 0; i < 3; i++)
            cycle(expect_ph(PH_TRAP, 1'b0, 1'b0), 1'($urandom), 6'($urandom), 1'($urandom), tag);
        do_reset();
    endtask

    task automatic req_phase(input int ph, input int wait_n, input string tag, output bit trapped);
        logic ack;
        trapped = 1'b0;
        for (int w = 0; w <= TO; w++) begin
            ack = (w == wait_n);
            cycle(expect_ph(ph, ack, 1'b0), ack, 6'($urandom), 1'($urandom), tag);
            if (ack) return;
        end
        trapped = 1'b1;
    endtask

    task automatic nonreq(input int ph, input string tag);
        cycle(expect_ph(ph, 1'b0, 1'b0), 1'($urandom), 6'($urandom), 1'($urandom), tag);
    endtask

    task automatic run_instr(input logic [5:0] op, input logic zero, input int wf, input int wm);
        bit t;
        req_phase(PH_FETCH, wf, "fetch", t);
        if (t) begin trap_tail("fetch_timeout_trap"); return; end
        cycle(expect_ph(PH_DEC, 1'b0, 1'b0), 1'($urandom), op, 1'($urandom), "decode");
        case (op)
            OP_R:    begin nonreq(PH_EXR, "exec_r"); nonreq(PH_WBR, "wb_r"); end
            OP_ADDI: begin nonreq(PH_EXI, "exec_i"); nonreq(PH_WBI, "wb_i"); end
            OP_LW: begin
                nonreq(PH_ADDR, "mem_addr_lw");
                req_phase(PH_RD, wm, "mem_rd", t);
                if (t) trap_tail("rd_timeout_trap");
                else nonreq(PH_WBM, "wb_mem");
            end
            OP_SW: begin
                nonreq(PH_ADDR, "mem_addr_sw");
                req_phase(PH_WR, wm, "mem_wr", t);
                if (t) trap_tail("wr_timeout_trap");
            end
            OP_BEQ: cycle(expect_ph(PH_BR, 1'b0, zero), 1'($urandom), 6'($urandom), zero, "branch");
            OP_J:   nonreq(PH_JMP, "jump");
            default: trap_tail("illegal_trap");
        endcase
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};
    endfunction

    function automatic int rnd_wait();
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 15) return TO;
        if (r == 14) return TO + 5;
        return r % 4;
    endfunction

    initial begin
        logic [5:0] legal [6];
        logic [5:0] op;
        legal = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};
        bus.Op_i     = '0;
        bus.Zero_i   = 1'b0;
        bus.MemAck_i = 1'b0;
        #1;
        check('0, "reset_at_start");
        @(negedge clk);
        rst = 1'b0;

        // J: legal here, trap in the HAS_JUMP=0 instance after its decode.
        run_instr(OP_J, 1'b0, 0, 0);
        checks++;
        assert (bus_nj.Err_o === 1'b1) else begin
            errors++;
            $error("FAIL no_jump_trap observed=%b expected=1", bus_nj.Err_o);
        end

        run_instr(OP_R, 1'b0, 0, 0);
        run_instr(OP_R, 1'b0, 0, 0);
        run_instr(OP_LW, 1'b0, 0, 3);
        run_instr(OP_SW, 1'b0, 0, TO);
        run_instr(OP_LW, 1'b0, TO, 0);
        run_instr(OP_BEQ, 1'b1, 0, 0);
        run_instr(OP_BEQ, 1'b0, 2, 0);
        run_instr(OP_ADDI, 1'b0, 1, 0);
        run_instr(6'b111111, 1'b0, 0, 0);
        run_instr(OP_SW, 1'b0, 0, TO + 1);

        // Reset during a pending read: request drops at once, fetch resumes.
        cycle(expect_ph(PH_FETCH, 1'b1, 1'b0), 1'b1, 6'($urandom), 1'b0, "pre_rst_fetch");
        cycle(expect_ph(PH_DEC, 1'b0, 1'b0), 1'b0, OP_LW, 1'b0, "pre_rst_decode");
        nonreq(PH_ADDR, "pre_rst_addr");
        cycle(expect_ph(PH_RD, 1'b0, 1'b0), 1'b0, 6'($urandom), 1'b0, "pre_rst_rd0");
        cycle(expect_ph(PH_RD, 1'b0, 1'b0), 1'b0, 6'($urandom), 1'b0, "pre_rst_rd1");
        #2;
        rst = 1'b1;
        #1;
        check('0, "mid_rd_async_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_instr(OP_R, 1'b0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                op = 6'($urandom);
                while (is_legal(op)) op = 6'($urandom);
            end else begin
                op = legal[$urandom_range(0, 5)];
            end
            run_instr(op, 1'($urandom), rnd_wait(), rnd_wait());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
